rx78_ram_uploader: RTL

- Responder for the HPS ioctl upload direction; it is the counterpart of the cartridge download path.
- When the HPS reads a save file, each `ioctl_rd` strobe carries an address. The block fetches that byte from the RX-78 extended RAM through a shared, arbitrated memory port, presents it on `ioctl_din`, and holds `ioctl_wait` until the byte is valid.
- It sits between `hps_io` and the RAM arbiter inside `emu`.

---
 rtl/rx78_pkg.sv | 13 +
 rtl/rx78_edge_det.sv | 26 ++
 rtl/rx78_ram_uploader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rx78_pkg.sv
// Shared types and constants for the RX-78 save-RAM upload path.
package rx78_pkg;

    typedef enum logic [1:0] {
        UPL_IDLE,
        UPL_FETCH,
        UPL_DONE
    } upl_state_t;

    localparam logic [7:0] UPL_SAVE_INDEX = 8'd2;
    localparam logic [7:0] UPL_FILL       = 8'hFF;

endpackage

// File: rtl/rx78_edge_det.sv
// Edge detector: registers the previous level and flags rising/falling
// transitions of a single-bit level in the cycle they are first seen.
module rx78_edge_det (
    input  logic clk_sys,
    input  logic reset,
    input  logic sig,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sig_reg;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sig_reg <= 1'b0;
        end else begin
            sig_reg <= sig;
        end
    end

    assign level = sig_reg;
    assign rise  = sig & ~sig_reg;
    assign fall  = ~sig & sig_reg;

endmodule

// File: rtl/rx78_ram_uploader.sv
// Serves HPS ioctl upload reads from the RX-78 extended RAM through an
// arbitrated request/acknowledge port, stalling the HPS until data is ready.
module rx78_ram_uploader
    import rx78_pkg::*;
#(
    parameter int         ADDR_W = 15,
    parameter int         SIZE   = 32768,
    parameter logic [7:0] FILL   = UPL_FILL,
    parameter logic [7:0] INDEX  = UPL_SAVE_INDEX
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_dout,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   rd_count,
    output logic              overrun
);

    // One extra bit so a SIZE of 2**25 still compares correctly.
    localparam logic [25:0]     SIZE_EXT = 26'(SIZE);
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    upl_state_t        state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              req_reg;
    logic              wait_reg;
    logic [7:0]        din_reg;
    logic              done_reg;
    logic [ADDR_W:0]   count_reg;
    logic              overrun_reg;
    logic              end_pending_reg;

    logic              sel;
    logic              sel_rise;
    logic              sel_fall;
    logic              rd_sel;
    logic              in_range;
    logic [ADDR_W:0]   count_inc;
    logic [ADDR_W:0]   count_served;

    assign sel      = ioctl_upload && (ioctl_index == INDEX);
    assign rd_sel   = ioctl_rd && sel;
    assign in_range = ({1'b0, ioctl_addr} < SIZE_EXT);

    assign count_inc    = (count_reg == '1) ? count_reg : count_reg + CNT_ONE;
    // A read served in the same cycle a session opens is its first read.
    assign count_served = sel_rise ? CNT_ONE : count_inc;

    rx78_edge_det u_sel_edge (
        .clk_sys (clk_sys),
        .reset   (reset),
        .sig     (sel),
        .level   (busy),
        .rise    (sel_rise),
        .fall    (sel_fall)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg       <= UPL_IDLE;
            addr_reg        <= '0;
            req_reg         <= 1'b0;
            wait_reg        <= 1'b0;
            din_reg         <= FILL;
            done_reg        <= 1'b0;
            count_reg       <= '0;
            overrun_reg     <= 1'b0;
            end_pending_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            if (sel_rise) begin
                count_reg   <= '0;
                overrun_reg <= 1'b0;
            end

            case (state_reg)
                UPL_IDLE: begin
                    if (sel_fall) begin
                        done_reg <= 1'b1;
                    end
                    if (rd_sel) begin
                        if (in_range) begin
                            addr_reg  <= ioctl_addr[ADDR_W-1:0];
                            req_reg   <= 1'b1;
                            wait_reg  <= 1'b1;
                            state_reg <= UPL_FETCH;
                        end else begin
                            din_reg   <= FILL;
                            count_reg <= count_served;
                        end
                    end
                end

                UPL_FETCH: begin
                    if (rd_sel) begin
                        overrun_reg <= 1'b1;
                    end
                    // The request is never withdrawn; a session end is
                    // remembered and reported once the arbiter answers.
                    if (sel_fall) begin
                        end_pending_reg <= 1'b1;
                    end
                    if (mem_ack) begin
                        din_reg         <= mem_dout;
                        req_reg         <= 1'b0;
                        wait_reg        <= 1'b0;
                        count_reg       <= count_served;
                        end_pending_reg <= 1'b0;
                        state_reg       <= (end_pending_reg || sel_fall) ? UPL_DONE : UPL_IDLE;
                    end
                end

                UPL_DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= UPL_IDLE;
                    if (rd_sel) begin
                        overrun_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= UPL_IDLE;
                end
            endcase
        end
    end

    assign ioctl_din  = din_reg;
    assign ioctl_wait = wait_reg;
    assign mem_req    = req_reg;
    assign mem_addr   = addr_reg;
    assign done       = done_reg;
    assign rd_count   = count_reg;
    assign overrun    = overrun_reg;

endmodule
